mem_lsu: RTL and testbench

Load/store unit in the MEM stage; the producer side of the write-back data path. It accepts one load or store per transaction from the MEM stage and runs a valid/ready request plus valid response exchange with data memory. It extracts and sign- or zero-extends load bytes and halfwords, and returns the result on mem_read_data_o, which feeds WB's mem_read_data_i. The pipeline stalls while a transaction is in flight.

---
 rtl/rv32i_pkg.sv | 32 +++
 rtl/mem_lsu_if.sv | 27 ++
 rtl/mem_lsu_align.sv | 78 +++++++
 rtl/mem_lsu.sv | 107 ++++++++++
 tb/tb_mem_lsu.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I types for the MEM-stage load/store unit.
//   data_t      : 32-bit data/address word
//   be_t        : 4-bit byte-enable mask
//   mem_op_t    : load/store opcode (4-bit enum; bit 3 marks a store)
//   lsu_state_t : LSU transaction FSM states
//   DATA_ZERO   : all-zero data word
package rv32i_pkg;
    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [3:0]      be_t;

    typedef enum logic [3:0] {
        MEM_LB  = 4'd0,
        MEM_LH  = 4'd1,
        MEM_LW  = 4'd2,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd8,
        MEM_SH  = 4'd9,
        MEM_SW  = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    localparam data_t DATA_ZERO = '0;
endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU (master) and data memory (slave).
//   dmem_req_valid_o/dmem_req_ready_i : request handshake
//   dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o : request fields
//   dmem_rsp_valid_i, dmem_rdata_i : load response
// Signal suffixes are from the LSU's point of view.
interface mem_lsu_if;
    import rv32i_pkg::*;

    logic  dmem_req_valid_o;
    logic  dmem_req_ready_i;
    logic  dmem_we_o;
    be_t   dmem_be_o;
    data_t dmem_addr_o;
    data_t dmem_wdata_o;
    logic  dmem_rsp_valid_i;
    data_t dmem_rdata_i;

    modport master (
        output dmem_req_valid_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_req_ready_i, dmem_rsp_valid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_valid_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_req_ready_i, dmem_rsp_valid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   i_op, i_off    : opcode and address byte offset
//   i_wdata        : raw store data (rs2)
//   i_rdata        : raw load word from memory
//   o_be           : byte enables
//   o_wdata        : lane-replicated store data
//   o_rdata        : extracted and extended load data
//   o_misalign     : access is misaligned or opcode undefined
//   o_store        : opcode is a store
module lsu_align
    import rv32i_pkg::*;
(
    input  mem_op_t    i_op,
    input  logic [1:0] i_off,
    input  data_t      i_wdata,
    input  data_t      i_rdata,
    output be_t        o_be,
    output data_t      o_wdata,
    output data_t      o_rdata,
    output logic       o_misalign,
    output logic       o_store
);
    data_t w_shifted;

    // Addressed byte/halfword moved down to lane 0.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_be       = '0;
        o_wdata    = i_wdata;
        o_rdata    = DATA_ZERO;
        o_misalign = 1'b0;
        o_store    = 1'b0;
        case (i_op)
            MEM_LB: begin
                o_be    = 4'b0001 << i_off;
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            MEM_LBU: begin
                o_be    = 4'b0001 << i_off;
                o_rdata = {24'd0, w_shifted[7:0]};
            end
            MEM_LH: begin
                o_be       = 4'b0011 << i_off;
                o_rdata    = {{16{w_shifted[15]}}, w_shifted[15:0]};
                o_misalign = i_off[0];
            end
            MEM_LHU: begin
                o_be       = 4'b0011 << i_off;
                o_rdata    = {16'd0, w_shifted[15:0]};
                o_misalign = i_off[0];
            end
            MEM_LW: begin
                o_be       = 4'b1111;
                o_rdata    = w_shifted;
                o_misalign = |i_off;
            end
            MEM_SB: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_store = 1'b1;
            end
            MEM_SH: begin
                o_be       = 4'b0011 << i_off;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_off[0];
                o_store    = 1'b1;
            end
            MEM_SW: begin
                o_be       = 4'b1111;
                o_misalign = |i_off;
                o_store    = 1'b1;
            end
            // Undefined encodings fault without touching the bus.
            default: o_misalign = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Accepts one load/store from the pipeline,
// runs a valid/ready request + valid response exchange with data memory,
// and returns extended load data to write-back.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o, mem_op_i, addr_i, wdata_i : pipeline request
//   rsp_valid_o, mem_read_data_o, misalign_o           : one-cycle completion
//   stall_o             : pipeline hold while a transaction is in flight
//   dmem                : data-memory bus (master side)
module mem_lsu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32   // byte-lane logic is fixed at 4 lanes
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  mem_op_t         mem_op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] mem_read_data_o,
    output logic            misalign_o,
    output logic            stall_o,
    mem_lsu_if.master       dmem
);
    lsu_state_t r_state, w_next;
    mem_op_t    r_op;
    data_t      r_addr;
    data_t      r_wdata;
    logic       r_misalign;
    data_t      r_rdata;

    logic       w_idle, w_req;
    mem_op_t    w_op;
    logic [1:0] w_off;
    be_t        w_be;
    data_t      w_wdata;
    data_t      w_rdata;
    logic       w_misalign, w_store;

    assign w_idle = (r_state == ST_IDLE);
    assign w_req  = (r_state == ST_REQ);

    // In IDLE the aligner looks at the incoming op to classify it before
    // capture; afterwards it works purely from the captured registers.
    assign w_op  = w_idle ? mem_op_i    : r_op;
    assign w_off = w_idle ? addr_i[1:0] : r_addr[1:0];

    lsu_align u_align (
        .i_op       (w_op),
        .i_off      (w_off),
        .i_wdata    (r_wdata),
        .i_rdata    (dmem.dmem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign),
        .o_store    (w_store)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid_i)           w_next = w_misalign ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem.dmem_req_ready_i) w_next = w_store ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem.dmem_rsp_valid_i) w_next = ST_DONE;
            ST_DONE:                            w_next = ST_IDLE;
            default:                            w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= MEM_LB;
            r_addr     <= DATA_ZERO;
            r_wdata    <= DATA_ZERO;
            r_misalign <= 1'b0;
            r_rdata    <= DATA_ZERO;
        end else begin
            r_state <= w_next;
            if (w_idle && req_valid_i) begin
                r_op       <= mem_op_i;
                r_addr     <= addr_i;
                r_wdata    <= wdata_i;
                r_misalign <= w_misalign;
                r_rdata    <= DATA_ZERO;   // stores and faults report 0
            end
            if (r_state == ST_WAIT && dmem.dmem_rsp_valid_i)
                r_rdata <= w_rdata;
        end
    end

    assign req_ready_o     = w_idle;
    assign rsp_valid_o     = (r_state == ST_DONE);
    assign misalign_o      = rsp_valid_o & r_misalign;
    assign mem_read_data_o = r_rdata;
    assign stall_o         = req_valid_i & ~rsp_valid_o;

    // Bus fields are zero outside REQ so nothing stale leaks onto the bus.
    assign dmem.dmem_req_valid_o = w_req;
    assign dmem.dmem_we_o        = w_req & w_store;
    assign dmem.dmem_be_o        = w_req ? w_be : '0;
    assign dmem.dmem_addr_o      = w_req ? {r_addr[31:2], 2'b00} : DATA_ZERO;
    assign dmem.dmem_wdata_o     = w_req ? w_wdata : DATA_ZERO;
endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import rv32i_pkg::*;

    typedef struct packed {
        logic  mis;
        data_t data;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    req_valid_i;
    logic    req_ready_o;
    mem_op_t mem_op_i;
    data_t   addr_i;
    data_t   wdata_i;
    logic    rsp_valid_o;
    data_t   mem_read_data_o;
    logic    misalign_o;
    logic    stall_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t scb[$];

    mem_lsu_if u_if ();

    mem_lsu #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .mem_op_i        (mem_op_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .mem_read_data_o (mem_read_data_o),
        .misalign_o      (misalign_o),
        .stall_o         (stall_o),
        .dmem            (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid_o === 1'b1) begin
            if (scb.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid_o}, 32'd0);
            end else begin
                exp_t e;
                e = scb.pop_front();
                chk("rsp_data", mem_read_data_o, e.data);
                chk("rsp_misalign", {31'd0, misalign_o}, {31'd0, e.mis});
            end
        end
    end

    // One transaction with a cooperative memory: ready after rdy_wait REQ
    // cycles, load data returned the cycle after the handshake.
    task automatic run_op(input string tag, input mem_op_t op, input data_t addr,
                          input data_t wd, input data_t rd, input int rdy_wait,
                          input be_t ebe, input data_t ewd, input data_t edata,
                          input logic emis, input int elat);
        int   acc, nreq, lat;
        bit   hs_pend, done;
        logic ewe;
        ewe = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
        @(negedge clk);
        req_valid_i = 1'b1; mem_op_i = op; addr_i = addr; wdata_i = wd;
        u_if.dmem_req_ready_i = 1'b0; u_if.dmem_rsp_valid_i = 1'b0;
        scb.push_back({emis, edata});
        acc = cyc + 1; nreq = 0; lat = 0; hs_pend = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            u_if.dmem_rsp_valid_i = 1'b0;
            u_if.dmem_rdata_i     = '0;
            if (hs_pend) begin
                u_if.dmem_rsp_valid_i = 1'b1;
                u_if.dmem_rdata_i     = rd;
                hs_pend = 0;
            end
            chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, ~rsp_valid_o});
            if (rsp_valid_o) begin
                lat  = cyc - acc + 1;
                done = 1;
            end else if (u_if.dmem_req_valid_o) begin
                nreq++;
                chk({tag, "_be"}, {28'd0, u_if.dmem_be_o}, {28'd0, ebe});
                chk({tag, "_addr"}, u_if.dmem_addr_o, addr & 32'hFFFF_FFFC);
                chk({tag, "_we"}, {31'd0, u_if.dmem_we_o}, {31'd0, ewe});
                if (ewe) chk({tag, "_wdata"}, u_if.dmem_wdata_o, ewd);
                if (nreq > rdy_wait) begin
                    u_if.dmem_req_ready_i = 1'b1;
                    hs_pend = !ewe;
                end else begin
                    u_if.dmem_req_ready_i = 1'b0;
                end
            end else begin
                u_if.dmem_req_ready_i = 1'b0;
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_nreq"}, nreq, emis ? 0 : rdy_wait + 1);
        req_valid_i = 1'b0;
        u_if.dmem_req_ready_i = 1'b0;
        u_if.dmem_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse1"}, {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; mem_op_i = MEM_LB; addr_i = '0; wdata_i = '0;
        u_if.dmem_req_ready_i = 1'b0; u_if.dmem_rsp_valid_i = 1'b0; u_if.dmem_rdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst_req_valid", {31'd0, u_if.dmem_req_valid_o}, 32'd0);
        chk("rst_we", {31'd0, u_if.dmem_we_o}, 32'd0);
        chk("rst_be", {28'd0, u_if.dmem_be_o}, 32'd0);
        chk("rst_addr", u_if.dmem_addr_o, 32'd0);
        chk("rst_wdata", u_if.dmem_wdata_o, 32'd0);
        chk("rst_rdata", mem_read_data_o, 32'd0);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        rst = 1'b0;

        //     tag     op       addr        wdata         rdata         wait be       ewdata        edata         mis   lat
        run_op("lw",   MEM_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 3);
        run_op("lb",   MEM_LB,  32'h103, 32'h0,        32'h80000000, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 3);
        run_op("lbu",  MEM_LBU, 32'h103, 32'h0,        32'h80000000, 0, 4'b1000, 32'h0,        32'h00000080, 1'b0, 3);
        run_op("sb",   MEM_SB,  32'h202, 32'h000000A5, 32'h0,        0, 4'b0100, 32'hA5A5A5A5, 32'h0,        1'b0, 2);
        run_op("lh_m", MEM_LH,  32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        run_op("sw_w", MEM_SW,  32'h300, 32'h12345678, 32'h0,        3, 4'b1111, 32'h12345678, 32'h0,        1'b0, 5);
        run_op("sh",   MEM_SH,  32'h102, 32'h0000BEEF, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 2);
        run_op("lh",   MEM_LH,  32'h102, 32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0, 3);
        run_op("lw_m", MEM_LW,  32'h102, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        run_op("sw_m", MEM_SW,  32'h301, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        run_op("undef", mem_op_t'(4'd3), 32'h0, 32'h0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1);
        run_op("lw_w", MEM_LW,  32'h104, 32'h0,        32'h01234567, 2, 4'b1111, 32'h0,        32'h01234567, 1'b0, 5);

        // A stray response while idle must be ignored.
        @(negedge clk);
        u_if.dmem_rsp_valid_i = 1'b1; u_if.dmem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        u_if.dmem_rsp_valid_i = 1'b0;
        chk("stray_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("stray_ready", {31'd0, req_ready_o}, 32'd1);

        // Reset while a load waits for data: back to IDLE, no completion.
        req_valid_i = 1'b1; mem_op_i = MEM_LW; addr_i = 32'h100;
        u_if.dmem_req_ready_i = 1'b1;
        @(negedge clk);
        chk("rstw_req_valid", {31'd0, u_if.dmem_req_valid_o}, 32'd1);
        @(negedge clk);
        u_if.dmem_req_ready_i = 1'b0;
        chk("rstw_in_wait", {31'd0, u_if.dmem_req_valid_o | req_ready_o | rsp_valid_o}, 32'd0);
        rst = 1'b1; req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_req_drop", {31'd0, u_if.dmem_req_valid_o}, 32'd0);
        chk("rstw_idle", {31'd0, req_ready_o}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstw_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end

        run_op("lhu",  MEM_LHU, 32'h2,   32'h0,        32'h80010000, 0, 4'b1100, 32'h0,        32'h00008001, 1'b0, 3);

        repeat (2) @(negedge clk);
        chk("scb_empty", scb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
